// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction-decode stage. Decodes the fetched word, reads a
//               2R/1W register file (write-first bypass) and registers the
//               decoded control, operands and immediate at the ID/EXE
//               boundary.
// Ports       : clk, rst (async, active-low)
//               Instruction_in   fetched word {op,rd,rs1,rs2/imm}
//               stall / flush    hold boundary / load NOP bubble
//               wb_en, wb_dest, wb_data   register-file write port
//               Instruction, EXE_Cmd, BR_Type, readdata1, readdata2,
//               Immediate, data2, mem_r_en, mem_w_en, wb_en_out, dest
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   Instruction_in,
    input  logic          stall,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [4:0]    wb_dest,
    input  logic [DW-1:0] wb_data,
    output logic [31:0]   Instruction,
    output logic [3:0]    EXE_Cmd,
    output logic [1:0]    BR_Type,
    output logic [DW-1:0] readdata1,
    output logic [DW-1:0] readdata2,
    output logic [DW-1:0] Immediate,
    output logic [DW-1:0] data2,
    output logic          mem_r_en,
    output logic          mem_w_en,
    output logic          wb_en_out,
    output logic [4:0]    dest
);

    localparam int          AW       = $clog2(NREGS);
    localparam logic [5:0]  c_OP_ST  = 6'd37;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_src2;
    logic [15:0] w_imm16;

    assign w_op    = Instruction_in[31:26];
    assign w_rd    = Instruction_in[25:21];
    assign w_rs1   = Instruction_in[20:16];
    assign w_rs2   = Instruction_in[15:11];
    assign w_imm16 = Instruction_in[15:0];
    // A store reads the value to be stored from its rd field.
    assign w_src2  = (w_op == c_OP_ST) ? w_rd : w_rs2;

    // ------------------------------------------------------------------
    // Control decode; unlisted op codes fall through to the NOP defaults
    // ------------------------------------------------------------------
    logic [3:0] w_cmd;
    logic [1:0] w_br;
    logic       w_is_imm;
    logic       w_mem_r;
    logic       w_mem_w;
    logic       w_wb;

    always_comb begin
        w_cmd    = 4'b0000;
        w_br     = 2'd0;
        w_is_imm = 1'b0;
        w_mem_r  = 1'b0;
        w_mem_w  = 1'b0;
        w_wb     = 1'b0;
        case (w_op)
            6'd1:  begin w_cmd = 4'b0000; w_wb = 1'b1; end
            6'd3:  begin w_cmd = 4'b0010; w_wb = 1'b1; end
            6'd5:  begin w_cmd = 4'b0100; w_wb = 1'b1; end
            6'd6:  begin w_cmd = 4'b0101; w_wb = 1'b1; end
            6'd7:  begin w_cmd = 4'b0110; w_wb = 1'b1; end
            6'd8:  begin w_cmd = 4'b0111; w_wb = 1'b1; end
            6'd9,
            6'd10: begin w_cmd = 4'b1000; w_wb = 1'b1; end
            6'd11: begin w_cmd = 4'b1001; w_wb = 1'b1; end
            6'd12: begin w_cmd = 4'b1010; w_wb = 1'b1; end
            6'd32: begin w_cmd = 4'b0000; w_wb = 1'b1; w_is_imm = 1'b1; end
            6'd33: begin w_cmd = 4'b0010; w_wb = 1'b1; w_is_imm = 1'b1; end
            6'd36: begin w_mem_r = 1'b1;  w_wb = 1'b1; w_is_imm = 1'b1; end
            6'd37: begin w_mem_w = 1'b1;  w_is_imm = 1'b1; end
            6'd40: w_br = 2'd1;
            6'd41: w_br = 2'd2;
            6'd42: w_br = 2'd3;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file: R0 is never written so it always reads zero.
    // ------------------------------------------------------------------
    logic [DW-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_dest != 5'd0)) begin
            r_regs[wb_dest[AW-1:0]] <= wb_data;
        end
    end

    // Write-first bypass so a value written this cycle is seen by decode.
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;

    always_comb begin
        if (w_rs1 == 5'd0)
            w_rd1 = '0;
        else if (wb_en && (wb_dest == w_rs1))
            w_rd1 = wb_data;
        else
            w_rd1 = r_regs[w_rs1[AW-1:0]];

        if (w_src2 == 5'd0)
            w_rd2 = '0;
        else if (wb_en && (wb_dest == w_src2))
            w_rd2 = wb_data;
        else
            w_rd2 = r_regs[w_src2[AW-1:0]];
    end

    logic [DW-1:0] w_imm_ext;
    assign w_imm_ext = {{(DW-16){w_imm16[15]}}, w_imm16};

    // ------------------------------------------------------------------
    // ID/EXE boundary: flush beats stall, an all-zero load is a bubble.
    // ------------------------------------------------------------------
    logic [31:0]   r_instr;
    logic [3:0]    r_cmd;
    logic [1:0]    r_br;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_data2;
    logic          r_mem_r;
    logic          r_mem_w;
    logic          r_wb;
    logic [4:0]    r_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            r_instr <= '0;
            r_cmd   <= '0;
            r_br    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_data2 <= '0;
            r_mem_r <= 1'b0;
            r_mem_w <= 1'b0;
            r_wb    <= 1'b0;
            r_dest  <= '0;
        end else if (!stall) begin
            r_instr <= Instruction_in;
            r_cmd   <= w_cmd;
            r_br    <= w_br;
            r_rd1   <= w_rd1;
            r_rd2   <= w_rd2;
            r_imm   <= w_imm_ext;
            r_data2 <= w_is_imm ? w_imm_ext : w_rd2;
            r_mem_r <= w_mem_r;
            r_mem_w <= w_mem_w;
            r_wb    <= w_wb;
            r_dest  <= w_rd;
        end
    end

    assign Instruction = r_instr;
    assign EXE_Cmd     = r_cmd;
    assign BR_Type     = r_br;
    assign readdata1   = r_rd1;
    assign readdata2   = r_rd2;
    assign Immediate   = r_imm;
    assign data2       = r_data2;
    assign mem_r_en    = r_mem_r;
    assign mem_w_en    = r_mem_w;
    assign wb_en_out   = r_wb;
    assign dest        = r_dest;

endmodule
`default_nettype wire
